// File: rtl/multi_digit_bcd_counter_pkg.sv
// Shared constants for the multi-digit BCD counter: digit width and the
// active-low seven-segment patterns {a,b,c,d,e,f,g,dp} with a in bit 7.
package multi_digit_bcd_counter_pkg;

   localparam int BCD_W = 4;

   typedef logic [BCD_W-1:0] bcd_t;

   localparam bcd_t BCD_MAX = 4'd9;

   localparam logic [7:0] SEG_0     = 8'b0000_0011;
   localparam logic [7:0] SEG_1     = 8'b1001_1111;
   localparam logic [7:0] SEG_2     = 8'b0010_0101;
   localparam logic [7:0] SEG_3     = 8'b0000_1101;
   localparam logic [7:0] SEG_4     = 8'b1001_1001;
   localparam logic [7:0] SEG_5     = 8'b0100_1001;
   localparam logic [7:0] SEG_6     = 8'b0100_0001;
   localparam logic [7:0] SEG_7     = 8'b0001_1111;
   localparam logic [7:0] SEG_8     = 8'b0000_0001;
   localparam logic [7:0] SEG_9     = 8'b0000_1001;
   localparam logic [7:0] SEG_BLANK = 8'b1111_1111;

   // Codes 10..15 never reach the display because loads saturate at 9.
   function automatic logic [7:0] bcdToSeg(input bcd_t d);
      case (d)
         4'd0:    bcdToSeg = SEG_0;
         4'd1:    bcdToSeg = SEG_1;
         4'd2:    bcdToSeg = SEG_2;
         4'd3:    bcdToSeg = SEG_3;
         4'd4:    bcdToSeg = SEG_4;
         4'd5:    bcdToSeg = SEG_5;
         4'd6:    bcdToSeg = SEG_6;
         4'd7:    bcdToSeg = SEG_7;
         4'd8:    bcdToSeg = SEG_8;
         4'd9:    bcdToSeg = SEG_9;
         default: bcdToSeg = SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the counter: steps up or down when its carry/borrow input is
// set, and reports carry (9->0) or borrow (0->9) to the next decade.
module bcd_digit
   import multi_digit_bcd_counter_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_load,
   input  bcd_t i_loadVal,
   input  logic i_up,
   input  logic i_carryIn,
   output bcd_t o_digit,
   output logic o_carryOut
);

   bcd_t r_digit;

   assign o_carryOut = i_carryIn && (i_up ? (r_digit == BCD_MAX) : (r_digit == '0));
   assign o_digit    = r_digit;

   // Loaded values above 9 are clamped so the digit always stays valid BCD.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_digit <= '0;
      end else if (i_clr) begin
         r_digit <= '0;
      end else if (i_load) begin
         r_digit <= (i_loadVal > BCD_MAX) ? BCD_MAX : i_loadVal;
      end else if (i_carryIn) begin
         if (i_up) r_digit <= (r_digit == BCD_MAX) ? '0 : r_digit + 1'b1;
         else      r_digit <= (r_digit == '0) ? BCD_MAX : r_digit - 1'b1;
      end
   end

endmodule

// File: rtl/multi_digit_bcd_counter.sv
// Prescaled up/down BCD counter with a multiplexed, active-low seven-segment
// display driver and optional leading-zero blanking.
module multi_digit_bcd_counter
   import multi_digit_bcd_counter_pkg::*;
#(
   parameter int NDIG     = 3,
   parameter int TICK_DIV = 4194304,
   parameter int SCAN_DIV = 32768
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_en,
   input  logic                    i_up,
   input  logic                    i_clr,
   input  logic                    i_load,
   input  logic [BCD_W*NDIG-1:0]   i_loadVal,
   input  logic                    i_blankLz,
   output logic [BCD_W*NDIG-1:0]   o_count,
   output logic                    o_tc,
   output logic [7:0]              o_seg,
   output logic [NDIG-1:0]         o_com
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0]   SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [NDIG-1:0] COM_RESET  = ~(NDIG'(1));

   logic [PW-1:0]         r_presc;
   logic [SW-1:0]         r_scan;
   logic [NDIG-1:0]       r_com;
   logic                  r_tc;
   logic                  w_hold;
   logic                  w_tick;
   logic [NDIG:0]         w_carry;
   logic [BCD_W*NDIG-1:0] w_count;
   logic [NDIG:0]         w_upperZero;
   logic [3:0]            w_lowCnt;
   bcd_t                  w_actDigit;
   logic                  w_actBlank;
   logic [7:0]            w_seg;

   assign w_hold     = i_clr | i_load;
   assign w_tick     = i_en && (r_presc == PRESC_LAST);
   assign w_carry[0] = w_tick;

   for (genvar g = 0; g < NDIG; g++) begin : gDigit
      bcd_digit uDigit (
         .i_clk      (i_clk),
         .i_rst_n    (i_rst_n),
         .i_clr      (i_clr),
         .i_load     (i_load),
         .i_loadVal  (i_loadVal[g*BCD_W +: BCD_W]),
         .i_up       (i_up),
         .i_carryIn  (w_carry[g]),
         .o_digit    (w_count[g*BCD_W +: BCD_W]),
         .o_carryOut (w_carry[g+1])
      );
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_presc <= '0;
      end else if (w_hold) begin
         r_presc <= '0;
      end else if (i_en) begin
         r_presc <= w_tick ? '0 : r_presc + 1'b1;
      end
   end

   // A carry out of the top decade means the whole count wrapped on this tick.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_tc <= 1'b0;
      else          r_tc <= !w_hold && w_carry[NDIG];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_scan <= '0;
         r_com  <= COM_RESET;
      end else if (r_scan == SCAN_LAST) begin
         r_scan <= '0;
         r_com  <= (r_com << 1) | (r_com >> (NDIG - 1));
      end else begin
         r_scan <= r_scan + 1'b1;
      end
   end

   // w_upperZero[k] is set when digits k..NDIG-1 are all zero.
   always_comb begin
      w_upperZero       = '0;
      w_upperZero[NDIG] = 1'b1;
      w_lowCnt          = '0;
      w_actDigit        = '0;
      w_actBlank        = 1'b0;
      w_seg             = SEG_BLANK;
      for (int k = NDIG - 1; k >= 0; k--) begin
         w_upperZero[k] = (w_count[k*BCD_W +: BCD_W] == '0) && w_upperZero[k+1];
      end
      for (int k = 0; k < NDIG; k++) begin
         if (!r_com[k]) begin
            w_lowCnt   = w_lowCnt + 1'b1;
            w_actDigit = w_count[k*BCD_W +: BCD_W];
            w_actBlank = i_blankLz && (k != 0) && w_upperZero[k];
         end
      end
      if (w_lowCnt == 4'd1) begin
         w_seg = w_actBlank ? SEG_BLANK : bcdToSeg(w_actDigit);
      end
   end

   assign o_count = w_count;
   assign o_tc    = r_tc;
   assign o_com   = r_com;
   assign o_seg   = w_seg;

endmodule

// File: tb/tb_multi_digit_bcd_counter.sv
// Directed self-checking bench for multi_digit_bcd_counter with NDIG=3,
// TICK_DIV=4, SCAN_DIV=2.
module tb_multi_digit_bcd_counter;

   localparam int NDIG     = 3;
   localparam int TICK_DIV = 4;
   localparam int SCAN_DIV = 2;

   typedef struct {
      string       name;
      logic        en;
      logic        up;
      logic        clr;
      logic        load;
      logic [11:0] loadVal;
      int          cyc;
      logic [11:0] expCount;
      logic        expTc;
   } vec_t;

   logic        clk;
   logic        rstN;
   logic        en;
   logic        up;
   logic        clr;
   logic        load;
   logic        blankLz;
   logic [11:0] loadVal;
   logic [11:0] count;
   logic        tc;
   logic [7:0]  seg;
   logic [2:0]  com;

   int errors = 0;
   int checks = 0;
   vec_t vecs[$];

   multi_digit_bcd_counter #(
      .NDIG     (NDIG),
      .TICK_DIV (TICK_DIV),
      .SCAN_DIV (SCAN_DIV)
   ) dut (
      .i_clk     (clk),
      .i_rst_n   (rstN),
      .i_en      (en),
      .i_up      (up),
      .i_clr     (clr),
      .i_load    (load),
      .i_loadVal (loadVal),
      .i_blankLz (blankLz),
      .o_count   (count),
      .o_tc      (tc),
      .o_seg     (seg),
      .o_com     (com)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [7:0] segOf(input logic [3:0] d);
      case (d)
         4'd0:    return 8'b00000011;
         4'd1:    return 8'b10011111;
         4'd2:    return 8'b00100101;
         4'd3:    return 8'b00001101;
         4'd4:    return 8'b10011001;
         4'd5:    return 8'b01001001;
         4'd6:    return 8'b01000001;
         4'd7:    return 8'b00011111;
         4'd8:    return 8'b00000001;
         4'd9:    return 8'b00001001;
         default: return 8'b11111111;
      endcase
   endfunction

   function automatic logic [11:0] toBcd(input int v);
      return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   function automatic logic [7:0] expSeg(input logic [11:0] val, input int k, input logic blank);
      logic [3:0] d;
      d = val[k*4 +: 4];
      if (blank && k > 0 && (val >> (4 * k)) == 12'h000) return 8'hFF;
      return segOf(d);
   endfunction

   function automatic vec_t mkVec(input string name, input logic e, input logic u, input logic c,
                                  input logic l, input logic [11:0] lv, input int cyc,
                                  input logic [11:0] ec, input logic et);
      vec_t v;
      v.name = name; v.en = e; v.up = u; v.clr = c; v.load = l; v.loadVal = lv;
      v.cyc = cyc; v.expCount = ec; v.expTc = et;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Strobes clr/load only for the first clock of the vector.
   task automatic applyStimulus(input vec_t v);
      en = v.en; up = v.up; clr = v.clr; load = v.load; loadVal = v.loadVal;
      for (int c = 0; c < v.cyc; c++) begin
         @(negedge clk);
         clr = 1'b0;
         load = 1'b0;
      end
   endtask

   task automatic loadValue(input logic [11:0] v);
      load = 1'b1;
      loadVal = v;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic checkScan(input logic [11:0] val, input logic blank, input string tag);
      logic [2:0] prev;
      logic [2:0] expCom;
      int n;
      n = 0;
      prev = com;
      while (!(com == 3'b110 && prev != 3'b110) && n < 8) begin
         prev = com;
         @(negedge clk);
         n++;
      end
      if (!(com == 3'b110 && prev != 3'b110)) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s_sync: got com=%b, expected entry into 110", tag, com);
      end else begin
         for (int j = 0; j < 6; j++) begin
            expCom = ~(3'b001 << (j / 2));
            checkOutput({tag, "_com"}, 32'(com), 32'(expCom));
            checkOutput({tag, "_seg"}, 32'(seg), 32'(expSeg(val, j / 2, blank)));
            if (j < 5) @(negedge clk);
         end
      end
   endtask

   initial begin
      int changes;
      logic [2:0] prevCom;

      rstN = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0;
      loadVal = '0; blankLz = 1'b0;
      #23;
      checkOutput("rst_count", 32'(count), 32'h000);
      checkOutput("rst_tc", 32'(tc), 32'h0);
      checkOutput("rst_com", 32'(com), 32'b110);
      checkOutput("rst_seg", 32'(seg), 32'b00000011);
      @(negedge clk);
      rstN = 1'b1;

      vecs.push_back(mkVec("inc1",     1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 4,  12'h001, 1'b0));
      vecs.push_back(mkVec("inc10",    1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 36, 12'h010, 1'b0));
      vecs.push_back(mkVec("ldSat1A0", 1'b1, 1'b1, 1'b0, 1'b1, 12'h1A0, 1,  12'h190, 1'b0));
      vecs.push_back(mkVec("ldSatFFF", 1'b1, 1'b1, 1'b0, 1'b1, 12'hFFF, 1,  12'h999, 1'b0));
      vecs.push_back(mkVec("wrapUp",   1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 4,  12'h000, 1'b1));
      vecs.push_back(mkVec("tcDrop",   1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 1,  12'h000, 1'b0));
      vecs.push_back(mkVec("wrapDown", 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 3,  12'h999, 1'b1));
      vecs.push_back(mkVec("ld0A9",    1'b1, 1'b0, 1'b0, 1'b1, 12'h0A9, 1,  12'h099, 1'b0));
      vecs.push_back(mkVec("carry",    1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 4,  12'h100, 1'b0));
      vecs.push_back(mkVec("borrow",   1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 4,  12'h099, 1'b0));
      vecs.push_back(mkVec("clrLd",    1'b1, 1'b1, 1'b1, 1'b1, 12'h555, 1,  12'h000, 1'b0));
      vecs.push_back(mkVec("hold",     1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 20, 12'h000, 1'b0));
      vecs.push_back(mkVec("ld009",    1'b1, 1'b1, 1'b0, 1'b1, 12'h009, 4,  12'h009, 1'b0));
      vecs.push_back(mkVec("carry010", 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 1,  12'h010, 1'b0));
      vecs.push_back(mkVec("ld999",    1'b1, 1'b0, 1'b0, 1'b1, 12'h999, 1,  12'h999, 1'b0));
      vecs.push_back(mkVec("dec998",   1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 4,  12'h998, 1'b0));
      vecs.push_back(mkVec("clr",      1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 1,  12'h000, 1'b0));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput({vecs[i].name, "_count"}, 32'(count), 32'(vecs[i].expCount));
         checkOutput({vecs[i].name, "_tc"}, 32'(tc), 32'(vecs[i].expTc));
      end

      // Full up-count sweep from reset through the wrap.
      rstN = 1'b0;
      @(negedge clk);
      rstN = 1'b1; en = 1'b1; up = 1'b1;
      for (int i = 1; i <= 1000; i++) begin
         repeat (4) @(negedge clk);
         checkOutput("sweep_count", 32'(count), 32'(toBcd(i % 1000)));
         checkOutput("sweep_tc", 32'(tc), (i == 1000) ? 32'h1 : 32'h0);
      end
      @(negedge clk);
      checkOutput("sweep_tcAfter", 32'(tc), 32'h0);

      // Saturating load followed by a down-count to the wrap.
      up = 1'b0;
      loadValue(12'h1A0);
      checkOutput("down_load", 32'(count), 32'h190);
      for (int i = 1; i <= 191; i++) begin
         repeat (4) @(negedge clk);
         if (i == 190) begin
            checkOutput("down_zero", 32'(count), 32'h000);
            checkOutput("down_zeroTc", 32'(tc), 32'h0);
         end
      end
      checkOutput("down_wrap", 32'(count), 32'h999);
      checkOutput("down_wrapTc", 32'(tc), 32'h1);

      // clr+load, then load alone, each landing on a tick.
      repeat (3) @(negedge clk);
      clr = 1'b1; load = 1'b1; loadVal = 12'h123;
      @(negedge clk);
      clr = 1'b0; load = 1'b0; up = 1'b1;
      checkOutput("tickClr_count", 32'(count), 32'h000);
      checkOutput("tickClr_tc", 32'(tc), 32'h0);
      repeat (3) @(negedge clk);
      loadValue(12'h123);
      checkOutput("tickLoad_count", 32'(count), 32'h123);
      repeat (3) @(negedge clk);
      checkOutput("tickLoad_lost", 32'(count), 32'h123);
      @(negedge clk);
      checkOutput("tickLoad_next", 32'(count), 32'h124);

      // Display scan and leading-zero blanking with the count frozen.
      en = 1'b0; blankLz = 1'b1;
      loadValue(12'h007);
      checkScan(12'h007, 1'b1, "blank007");
      blankLz = 1'b0;
      checkScan(12'h007, 1'b0, "noblank007");
      blankLz = 1'b1;
      loadValue(12'h107);
      checkScan(12'h107, 1'b1, "blank107");
      loadValue(12'h000);
      checkScan(12'h000, 1'b1, "blank000");
      loadValue(12'h020);
      checkScan(12'h020, 1'b1, "blank020");
      blankLz = 1'b0;

      // Enable gap mid-prescale: count frozen, scan keeps running.
      loadValue(12'h200);
      en = 1'b1;
      repeat (2) @(negedge clk);
      en = 1'b0;
      changes = 0;
      prevCom = com;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (com != prevCom) changes++;
         prevCom = com;
      end
      checkOutput("gap_count", 32'(count), 32'h200);
      checkOutput("gap_comSteps", 32'(changes), 32'd25);
      en = 1'b1;
      @(negedge clk);
      checkOutput("gap_resume1", 32'(count), 32'h200);
      @(negedge clk);
      checkOutput("gap_resume2", 32'(count), 32'h201);

      // Asynchronous reset between clock edges.
      en = 1'b0;
      loadValue(12'h456);
      en = 1'b1; up = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("arst_pre", 32'(count), 32'h456);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("arst_count", 32'(count), 32'h000);
      checkOutput("arst_tc", 32'(tc), 32'h0);
      checkOutput("arst_com", 32'(com), 32'b110);
      checkOutput("arst_seg", 32'(seg), 32'b00000011);
      @(negedge clk);
      checkOutput("arst_held", 32'(count), 32'h000);
      checkOutput("arst_heldCom", 32'(com), 32'b110);
      rstN = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("arst_resume0", 32'(count), 32'h000);
      @(negedge clk);
      checkOutput("arst_resume1", 32'(count), 32'h001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
